instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch.sv | 178 +++++++++++++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: the fetch FSM state
// encoding, default bus widths, the opcode bit that marks a 2-byte
// instruction, and the NOP opcode value.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned LONG_BIT_DEF = 7;

  localparam logic [DATA_W_DEF-1:0] NOP_OP = '0;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_GAP = 3'd1,
    FETCH_ARG = 3'd2,
    HOLD      = 3'd3,
    REDIRECT  = 3'd4,
    REDIR_GAP = 3'd5
  } state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch sequencer on the consumer side of the program counter. It reads the
// current PC, issues program-memory reads, pulses the counter's increment or
// load controls, assembles 1- or 2-byte instructions and presents them to the
// decoder over a valid/ready handshake. Branch redirects flush any fetch in
// flight.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   pc                current PC from the counter (registered, lags pulses)
//   pc_inc            1-cycle pulse, PC <= PC+1
//   pc_load           1-cycle pulse, PC <= pc_load_addr
//   pc_load_addr      load value, valid while pc_load=1
//   mem_addr/mem_rd   read address/request, held until mem_ready
//   mem_rdata         read data, valid with mem_ready
//   mem_ready         read completes this cycle
//   instr_valid/ready decoder handshake
//   instr_opcode      opcode byte
//   instr_operand     operand byte, 0 for 1-byte instructions
//   instr_pc          address of the opcode byte
//   br_valid          1-cycle redirect request
//   br_target         redirect address
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LONG_BIT = LONG_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target
);

  state_e            state_q, state_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              rd;
  logic              inc;
  logic              load;
  logic              valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_OP;
      flush_q   <= 1'b0;
      tgt_q     <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      tgt_q     <= tgt_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    tgt_d     = tgt_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;
    rd        = 1'b0;
    inc       = 1'b0;
    load      = 1'b0;
    valid     = 1'b0;

    // Last redirect wins: the saved target always tracks the newest request.
    if (br_valid) begin
      tgt_d = br_target;
    end

    case (state_q)
      FETCH_OP: begin
        rd = 1'b1;
        if (mem_ready) begin
          if (flush_q || br_valid) begin
            // Byte belongs to the abandoned path: drop it, no pc_inc.
            flush_d = 1'b0;
            state_d = REDIRECT;
          end else begin
            inc       = 1'b1;
            opcode_d  = mem_rdata;
            operand_d = '0;
            ipc_d     = pc;
            state_d   = mem_rdata[LONG_BIT] ? FETCH_GAP : HOLD;
          end
        end else if (br_valid) begin
          // Read cannot be withdrawn; finish it and throw the data away.
          flush_d = 1'b1;
        end
      end

      FETCH_GAP: begin
        state_d = br_valid ? REDIRECT : FETCH_ARG;
      end

      FETCH_ARG: begin
        rd = 1'b1;
        if (mem_ready) begin
          if (flush_q || br_valid) begin
            flush_d = 1'b0;
            state_d = REDIRECT;
          end else begin
            inc       = 1'b1;
            operand_d = mem_rdata;
            state_d   = HOLD;
          end
        end else if (br_valid) begin
          flush_d = 1'b1;
        end
      end

      HOLD: begin
        valid = !br_valid;
        if (br_valid) begin
          state_d = REDIRECT;
        end else if (instr_ready) begin
          // Reuse the settle state as the post-handshake bubble.
          state_d = REDIR_GAP;
        end
      end

      REDIRECT: begin
        load    = 1'b1;
        state_d = br_valid ? REDIRECT : REDIR_GAP;
      end

      REDIR_GAP: begin
        state_d = br_valid ? REDIRECT : FETCH_OP;
      end

      default: begin
        state_d = FETCH_OP;
      end
    endcase

    // Outputs are forced quiet during reset so an in-flight read drops at once.
    if (rst) begin
      rd    = 1'b0;
      inc   = 1'b0;
      load  = 1'b0;
      valid = 1'b0;
    end
  end

  assign mem_rd        = rd;
  assign mem_addr      = rd ? pc : '0;
  assign pc_inc        = inc;
  assign pc_load       = load;
  assign pc_load_addr  = load ? tgt_q : '0;
  assign instr_valid   = valid;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC counter model and a wait-state
// programmable memory model.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc = 8'h00;
  logic       pc_inc, pc_load, mem_rd, mem_ready, instr_valid;
  logic [7:0] pc_load_addr, mem_addr, mem_rdata;
  logic       instr_ready = 1'b0;
  logic       br_valid = 1'b0;
  logic [7:0] br_target = 8'h00;
  logic [7:0] instr_opcode, instr_operand, instr_pc;

  logic [7:0]  mem [256];
  int unsigned wait_n = 0;
  int unsigned cnt = 0;

  int n_checks = 0;
  int n_fail = 0;
  int n_inc = 0;
  int n_acc = 0;
  int drop_err = 0;
  int addr_err = 0;
  int both_err = 0;
  int rd_n = 0;
  logic [7:0] rd_log [32];
  logic       p_rd = 1'b0;
  logic       p_rdy = 1'b0;
  logic       p_rst = 1'b1;
  logic [7:0] p_addr = 8'h00;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .DATA_W(8), .LONG_BIT(7)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
    .br_valid(br_valid), .br_target(br_target)
  );

  // Counter model and memory model
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_addr;
    else if (pc_inc) pc <= pc + 8'd1;
    cnt <= (!mem_rd || mem_ready) ? 0 : cnt + 1;
  end
  assign mem_ready = mem_rd && (cnt == wait_n);
  assign mem_rdata = mem[mem_addr];

  // Protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (p_rd && !p_rdy && !p_rst && !rst) begin
      if (!mem_rd) drop_err <= drop_err + 1;
      else if (mem_addr != p_addr) addr_err <= addr_err + 1;
    end
    if (pc_inc && pc_load) both_err <= both_err + 1;
    if (pc_inc) n_inc <= n_inc + 1;
    if (instr_valid && instr_ready) n_acc <= n_acc + 1;
    if (mem_rd && mem_ready && rd_n < 32) begin
      rd_log[rd_n] <= mem_addr;
      rd_n <= rd_n + 1;
    end
    p_rd <= mem_rd; p_rdy <= mem_ready; p_rst <= rst; p_addr <= mem_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rdy;
    logic       rd;
    logic [7:0] addr;
    logic       inc;
    logic       valid;
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] ipc;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int k;
    int inc0;
    int acc0;
    int rd0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h9A; mem[8'h03] = 8'h56;
    mem[8'h04] = 8'h85; mem[8'h05] = 8'h3C; mem[8'h06] = 8'h11;
    mem[8'h40] = 8'h22; mem[8'hFF] = 8'h80;

    //           rdy   rd    addr   inc   valid op     arg    ipc
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 8'h00, 8'h01};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 8'h00, 8'h01};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h9A, 8'h56, 8'h02};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

    // Reset state
    step(); step();
    check("rst_mem_rd", mem_rd, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", instr_opcode, 0);
    check("rst_operand", instr_operand, 0);
    check("rst_instr_pc", instr_pc, 0);
    rst = 1'b0;

    // Zero-wait fetch of short, short, long instructions from address 0
    foreach (vecs[i]) begin
      instr_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_mem_rd", i), mem_rd, vecs[i].rd);
      if (vecs[i].rd) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("v%0d_pc_inc", i), pc_inc, vecs[i].inc);
      check($sformatf("v%0d_pc_load", i), pc_load, 0);
      check($sformatf("v%0d_valid", i), instr_valid, vecs[i].valid);
      if (vecs[i].valid) begin
        check($sformatf("v%0d_opcode", i), instr_opcode, vecs[i].op);
        check($sformatf("v%0d_operand", i), instr_operand, vecs[i].arg);
        check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].ipc);
      end
      step();
    end
    instr_ready = 1'b0;

    // Long instruction at pc=4 with 2-wait memory
    wait_n = 2;
    inc0 = n_inc;
    rd0 = rd_n;
    check("long_start_pc", pc, 8'h04);
    for (k = 0; k < 30 && !instr_valid; k++) step();
    check("long_valid_timeout", instr_valid, 1);
    check("long_opcode", instr_opcode, 8'h85);
    check("long_operand", instr_operand, 8'h3C);
    check("long_instr_pc", instr_pc, 8'h04);
    check("long_inc_count", n_inc - inc0, 2);
    check("long_read_count", rd_n - rd0, 2);
    check("long_read0_addr", rd_log[rd0], 8'h04);
    check("long_read1_addr", rd_log[rd0+1], 8'h05);
    check("long_final_pc", pc, 8'h06);

    // Decoder stalls for 10 cycles: everything held
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", instr_valid, 1);
      check("stall_opcode", instr_opcode, 8'h85);
      check("stall_operand", instr_operand, 8'h3C);
      check("stall_instr_pc", instr_pc, 8'h04);
      check("stall_mem_rd", mem_rd, 0);
      check("stall_pulses", {pc_inc, pc_load}, 0);
    end
    acc0 = n_acc;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("stall_accept", n_acc - acc0, 1);

    // Redirect to 0x40 during an outstanding 3-wait opcode read
    wait_n = 3;
    step();
    inc0 = n_inc;
    check("flush_rd", mem_rd, 1);
    check("flush_addr", mem_addr, 8'h06);
    br_valid = 1'b1;
    br_target = 8'h40;
    #1;
    check("flush_no_inc_br", pc_inc, 0);
    step();
    br_valid = 1'b0;
    #1;
    for (k = 0; k < 10 && !mem_ready; k++) begin
      check("flush_rd_held", mem_rd, 1);
      step();
    end
    check("flush_ready_timeout", mem_ready, 1);
    check("flush_addr_stable", mem_addr, 8'h06);
    check("flush_discard_inc", pc_inc, 0);
    step();
    check("redir_load", pc_load, 1);
    check("redir_load_addr", pc_load_addr, 8'h40);
    check("redir_rd", mem_rd, 0);
    wait_n = 0;
    step();
    check("redir_gap_rd", mem_rd, 0);
    check("redir_pc", pc, 8'h40);
    step();
    check("redir_fetch_rd", mem_rd, 1);
    check("redir_fetch_addr", mem_addr, 8'h40);
    check("redir_no_inc_total", n_inc - inc0, 0);
    step();
    check("redir_valid", instr_valid, 1);
    check("redir_opcode", instr_opcode, 8'h22);
    check("redir_instr_pc", instr_pc, 8'h40);

    // Branch in HOLD while decoder says ready: not accepted, redirect to 0xFF
    acc0 = n_acc;
    instr_ready = 1'b1;
    br_valid = 1'b1;
    br_target = 8'hFF;
    #1;
    check("hold_br_valid_drop", instr_valid, 0);
    step();
    instr_ready = 1'b0;
    br_valid = 1'b0;
    #1;
    check("hold_br_not_accepted", n_acc - acc0, 0);
    check("hold_br_load", pc_load, 1);
    check("hold_br_load_addr", pc_load_addr, 8'hFF);
    step();
    check("wrap_pc_ff", pc, 8'hFF);
    check("wrap_gap_rd", mem_rd, 0);
    step();
    check("wrap_op_rd", mem_rd, 1);
    check("wrap_op_addr", mem_addr, 8'hFF);
    check("wrap_op_inc", pc_inc, 1);
    step();
    check("wrap_gap2_rd", mem_rd, 0);
    check("wrap_pc_0", pc, 8'h00);
    step();
    check("wrap_arg_rd", mem_rd, 1);
    check("wrap_arg_addr", mem_addr, 8'h00);
    step();
    check("wrap_valid", instr_valid, 1);
    check("wrap_opcode", instr_opcode, 8'h80);
    check("wrap_operand", instr_operand, 8'h12);
    check("wrap_instr_pc", instr_pc, 8'hFF);
    check("wrap_pc_1", pc, 8'h01);

    // Reset asserted in the middle of a 3-wait read
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_n = 3;
    step();
    check("rstmid_rd", mem_rd, 1);
    check("rstmid_addr", mem_addr, 8'h01);
    step();
    rst = 1'b1;
    #1;
    check("rstmid_rd_drop", mem_rd, 0);
    check("rstmid_inc", pc_inc, 0);
    step();
    rst = 1'b0;
    #1;
    check("rstmid_refetch_rd", mem_rd, 1);
    check("rstmid_refetch_addr", mem_addr, 8'h01);
    check("rstmid_valid", instr_valid, 0);
    for (k = 0; k < 10 && !instr_valid; k++) step();
    check("rstmid_valid_timeout", instr_valid, 1);
    check("rstmid_opcode", instr_opcode, 8'h34);
    check("rstmid_instr_pc", instr_pc, 8'h01);
    check("rstmid_pc", pc, 8'h02);

    step();
    check("proto_rd_drop", drop_err, 0);
    check("proto_addr_change", addr_err, 0);
    check("proto_both_pulses", both_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
